// File: rtl/pprm_stage_2_pipe_pkg.sv
// Shared types for the PPRM stage-2 pipeline register: nibble type,
// occupancy state enum and the data reset constant.
package pprm_pkg;

  typedef logic [3:0] nibble_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam nibble_t NIBBLE_RST = 4'h0;

  // Number of held entries implied by a state.
  function automatic logic [1:0] occ_of(state_e s);
    logic [1:0] n;
    case (s)
      ONE:     n = 2'd1;
      TWO:     n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pprm_stage_2_pipe_if.sv
// Handshake/data bundle between stage 1, this pipeline register and stage 3.
// slave = the pipeline block, master = the surrounding stages (or a bench).
interface pprm_stage_2_pipe_if;
  import pprm_pkg::*;

  logic    flush;
  logic    in_valid;
  logic    in_ready;
  nibble_t in_a;
  nibble_t in_b;
  nibble_t in_c;
  logic    out_valid;
  logic    out_ready;
  nibble_t out_a;
  nibble_t out_b;
  nibble_t out_d;
  logic [1:0] occupancy;

  modport slave (
    input  flush, in_valid, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_a, out_b, out_d, occupancy
  );

  modport master (
    output flush, in_valid, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_d, occupancy
  );

endinterface

// File: rtl/pprm_stage_2.sv
// PPRM stage 2: multiplicative inverse in GF(2^4), field polynomial
// x^4 + x + 1, with 0 mapped to 0. Purely combinational.
module pprm_stage_2
  import pprm_pkg::*;
(
  input  nibble_t i_c,
  output nibble_t o_d
);

  // Inverse lookup; each pair (c, d) satisfies c*d = 1 in the field.
  always_comb begin
    case (i_c)
      4'h0: o_d = 4'h0;
      4'h1: o_d = 4'h1;
      4'h2: o_d = 4'h9;
      4'h3: o_d = 4'hE;
      4'h4: o_d = 4'hD;
      4'h5: o_d = 4'hB;
      4'h6: o_d = 4'h7;
      4'h7: o_d = 4'h6;
      4'h8: o_d = 4'hF;
      4'h9: o_d = 4'h2;
      4'hA: o_d = 4'hC;
      4'hB: o_d = 4'h5;
      4'hC: o_d = 4'hA;
      4'hD: o_d = 4'h4;
      4'hE: o_d = 4'h3;
      default: o_d = 4'h8;
    endcase
  end

endmodule

// File: rtl/pprm_stage_2_pipe.sv
// Pipeline register between PPRM stage 1 and stage 3. Inverts C on the way
// in and stores {A, B, D}. Build option PPRM_S2_SKID_EN adds a skid entry so
// in_ready is purely registered; without it a single register is used and
// in_ready passes out_ready through combinationally.
//
//   state | meaning
//   EMPTY | nothing held, out_valid low
//   ONE   | output register holds a word
//   TWO   | output and skid registers both hold words (skid build only)
module pprm_stage_2_pipe
  import pprm_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  pprm_stage_2_pipe_if.slave   bus
);

  state_e  r_state, w_state_nxt;
  logic    r_live;
  nibble_t r_out_a, r_out_b, r_out_d;
  nibble_t w_d;
  logic    w_in_fire, w_out_fire, w_load_out;
`ifdef PPRM_S2_SKID_EN
  nibble_t r_skid_a, r_skid_b, r_skid_d;
  logic    w_load_skid, w_skid_to_out;
`endif

  pprm_stage_2 u_stage_2 (.i_c(bus.in_c), .o_d(w_d));

  assign bus.out_valid = (r_state != EMPTY);
`ifdef PPRM_S2_SKID_EN
  assign bus.in_ready  = r_live && (r_state != TWO);
`else
  assign bus.in_ready  = r_live && ((r_state == EMPTY) || bus.out_ready);
`endif
  assign bus.occupancy = occ_of(r_state);
  assign bus.out_a     = r_out_a;
  assign bus.out_b     = r_out_b;
  assign bus.out_d     = r_out_d;
  assign w_in_fire     = bus.in_valid && bus.in_ready;
  assign w_out_fire    = bus.out_valid && bus.out_ready;

  // in_ready stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_live <= 1'b0;
    else          r_live <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= EMPTY;
    else          r_state <= w_state_nxt;
  end

  // Next state and data-register load controls.
  always_comb begin
    w_state_nxt = r_state;
    w_load_out  = 1'b0;
`ifdef PPRM_S2_SKID_EN
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
`endif
    if (bus.flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ONE;
            w_load_out  = 1'b1;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_load_out = 1'b1;
`ifdef PPRM_S2_SKID_EN
          end else if (w_in_fire) begin
            w_state_nxt = TWO;
            w_load_skid = 1'b1;
`endif
          end else if (w_out_fire) begin
            w_state_nxt = EMPTY;
          end
        end
`ifdef PPRM_S2_SKID_EN
        TWO: begin
          if (w_out_fire) begin
            w_state_nxt   = ONE;
            w_skid_to_out = 1'b1;
          end
        end
`endif
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // Output register: new word from the input side, or the skid entry moving up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_a <= NIBBLE_RST;
      r_out_b <= NIBBLE_RST;
      r_out_d <= NIBBLE_RST;
    end else if (w_load_out) begin
      r_out_a <= bus.in_a;
      r_out_b <= bus.in_b;
      r_out_d <= w_d;
`ifdef PPRM_S2_SKID_EN
    end else if (w_skid_to_out) begin
      r_out_a <= r_skid_a;
      r_out_b <= r_skid_b;
      r_out_d <= r_skid_d;
`endif
    end
  end

`ifdef PPRM_S2_SKID_EN
  // Skid entry: catches the word accepted while the output is stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_skid_a <= NIBBLE_RST;
      r_skid_b <= NIBBLE_RST;
      r_skid_d <= NIBBLE_RST;
    end else if (w_load_skid) begin
      r_skid_a <= bus.in_a;
      r_skid_b <= bus.in_b;
      r_skid_d <= w_d;
    end
  end
`endif

endmodule

// File: doc/pprm_stage_2_pipe.md
PPRM_STAGE_2_PIPE -- requirements
Module: pprm_stage_2_pipe

Interface
- REQ-001 SHALL have parameter: none; all widths fixed (A, B, C, D 4 bits each).
- REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
- REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
- REQ-004 SHALL have port flush  input  1  synchronous clear of all held entries.
- REQ-005 SHALL have port in_valid  input  1  upstream (stage 1) word valid.
- REQ-006 SHALL have port in_ready  output  1  block can accept a word this cycle.
- REQ-007 SHALL have port in_a, in_b  input  4 each  byte halves forwarded from stage 1.
- REQ-008 SHALL have port in_c  input  4  stage-1 result to be inverted.
- REQ-009 SHALL have port out_valid  output  1  downstream (stage 3) word valid.
- REQ-010 SHALL have port out_ready  input  1  stage 3 side accepts word.
- REQ-011 SHALL have port out_a, out_b, out_d  output  4 each  forwarded A, B and inverted D for stage 3.
- REQ-012 SHALL have port occupancy  output  2  number of held entries (0..2).

Function
- REQ-013 SHALL transfer in on edge where in_valid && in_ready; out on edge where out_valid && out_ready.
- REQ-014 SHALL compute D = pprm_stage_2(in_c) combinationally before the input register; store {A,B,D}, not C.
- REQ-015 SHALL give 1-cycle latency: word accepted at edge k is on out_* with out_valid=1 after edge k.
- REQ-016 SHALL keep out_* stable and out_valid high while out_valid && !out_ready.
- REQ-017 SHALL deliver words in acceptance order; no loss, no duplication.
- REQ-018 SHALL use states EMPTY (occ 0), ONE (occ 1), TWO (occ 2, skid used); out_valid = (state != EMPTY).
- REQ-019 SHALL transition: EMPTY+in -> ONE; ONE+in+!out -> TWO; ONE+in+out -> ONE; ONE+out only -> EMPTY; TWO+out -> ONE; all others hold.
- REQ-020 SHALL in state TWO hold in_ready=0; on TWO->ONE the skid entry moves to the output register.
- REQ-021 SHALL on flush=1 go to EMPTY next edge regardless of in/out handshakes that cycle; a word presented that cycle is dropped.
- REQ-022 SHALL drive in_ready from registered state only (no combinational path from out_ready to in_ready).

Reset
- REQ-023 SHALL on reset_n=0 immediately force state EMPTY, out_valid=0, occupancy=0, in_ready=0.
- REQ-024 SHALL clear out_a/out_b/out_d to 4'h0 on reset; held data lost if reset asserts mid-operation.
- REQ-025 SHALL raise in_ready on the first clk edge after reset_n deasserts.

Configuration
- REQ-026 SHALL, with PPRM_S2_SKID_EN defined, implement the 2-entry behaviour of REQ-018..REQ-022 (full throughput, registered in_ready).
- REQ-027 SHALL, without PPRM_S2_SKID_EN, use a single register: state TWO unreachable, in_ready = (state==EMPTY) || out_ready (combinational), occupancy max 1, throughput still 1 word/cycle.

Structure
- REQ-028 SHALL place nibble type, state enum (EMPTY/ONE/TWO) and reset constant 4'h0 in shared package pprm_pkg.
- REQ-029 SHALL instantiate the existing combinational sub-module pprm_stage_2 (C[3:0] -> D[3:0]) once; no other sub-modules.

Verification
- REQ-030 SHALL cover: reset, then in_c=4'h0, a=4'h5, b=4'hA, out_ready=1 -> next cycle out_valid=1, out_a=5, out_b=A, out_d=0.
- REQ-031 SHALL cover: all 16 in_c values streamed back-to-back, out_ready=1 -> 16 outputs in order, out_d equals a standalone pprm_stage_2 reference, no bubbles.
- REQ-032 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> occupancy 1 then 2, in_ready=0, outputs stable; release -> both words in order.
- REQ-033 SHALL cover: flush in state TWO with in_valid=1 -> next cycle occupancy=0, out_valid=0, flushed-cycle word never emitted.
- REQ-034 SHALL cover: reset_n pulsed low mid-stream between edges -> out_valid drops immediately, outputs 0, recovery per REQ-025.
- REQ-035 SHALL cover: build without PPRM_S2_SKID_EN, out_ready toggling 1/0 each cycle -> occupancy never exceeds 1, order preserved.
